// File: rtl/usb_in_tx_pkg.sv
// Shared USB SIE types and helpers: PID encodings, CRC16 constants and byte-wide CRC step.
// Used by both the transmit and receive sides of the device SIE.
package usb_in_tx_pkg;

    typedef enum logic [3:0] {
        PidOut   = 4'h1,
        PidIn    = 4'h9,
        PidSof   = 4'h5,
        PidSetup = 4'hD,
        PidData0 = 4'h3,
        PidData1 = 4'hB,
        PidAck   = 4'h2,
        PidNak   = 4'hA,
        PidStall = 4'hE
    } pid_t;

    typedef enum logic [2:0] {
        StIdle,
        StPid,
        StData,
        StCrcLo,
        StCrcHi,
        StEop,
        StWaitAck,
        StFin
    } tx_state_e;

    localparam logic [15:0] CrcPoly     = 16'hA001;
    localparam logic [15:0] CrcInit     = 16'hFFFF;
    // Remainder left after a correct packet including its inverted CRC, bit-reversed form.
    localparam logic [15:0] CrcResidual = 16'hB001;

    // A PID byte carries its own check nibble in the upper half.
    function automatic logic valid_pid(input logic [7:0] b);
        return b[7:4] == ~b[3:0];
    endfunction

    function automatic logic [7:0] tx_pid(input pid_t p);
        logic [3:0] v;
        v = p;
        return {~v, v};
    endfunction

    function automatic logic [15:0] step_crc16(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CrcPoly) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/usb_crc16_gen.sv
// Byte-wide, LSB-first CRC16 accumulator with synchronous clear and enable.
module usb_crc16_gen
    import usb_in_tx_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = CrcInit;
        end else if (en_i) begin
            crc_d = step_crc16(crc_q, data_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc_q <= CrcInit;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/usb_in_tx.sv
// Low-speed USB IN data stage transmitter: PID, payload, CRC16, then host handshake wait.
// Define USB_IN_TIMEOUT_EN to build the handshake timeout counter.
module usb_in_tx
    import usb_in_tx_pkg::*;
#(
    parameter int unsigned NumEndp       = 1,
    parameter int unsigned MaxPacket     = 8,
    parameter int unsigned TimeoutCycles = 288
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [1:0]         start_endp_i,
    input  logic               nak_i,
    input  logic               stall_i,
    input  logic [NumEndp-1:0] toggle_clr_i,
    input  logic [7:0]         endpi_data_i,
    input  logic               endpi_valid_i,
    input  logic               endpi_last_i,
    input  logic               endpi_zlp_i,
    output logic               endpi_ready_o,
    output logic [7:0]         tx_data_o,
    output logic               tx_valid_o,
    input  logic               tx_ready_i,
    input  logic [7:0]         rx_data_i,
    input  logic               rx_valid_i,
    input  logic               rx_active_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               acked_o,
    output logic [NumEndp-1:0] toggle_o
);

    localparam int unsigned CntW = $clog2(MaxPacket + 1);

    tx_state_e         state_q, state_d;
    pid_t              pid_q, pid_d;
    logic [1:0]        endp_q, endp_d;
    logic              hs_q, hs_d;
    logic              zlp_q, zlp_d;
    logic              underrun_q, underrun_d;
    logic              acked_q, acked_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [NumEndp-1:0] toggle_q, toggle_d;
    logic              start_toggle;
    logic              flip;
    logic              crc_clr, crc_en;
    logic [15:0]       crc;

    usb_crc16_gen u_crc (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (crc_clr),
        .en_i   (crc_en),
        .data_i (endpi_data_i),
        .crc_o  (crc)
    );

`ifdef USB_IN_TIMEOUT_EN
    localparam int unsigned TmrW = $clog2(TimeoutCycles + 1);
    logic [TmrW-1:0] timer_q, timer_d;
`else
    logic unused_rx_active;
    assign unused_rx_active = rx_active_i;
`endif

    always_comb begin
        start_toggle = 1'b0;
        for (int i = 0; i < NumEndp; i++) begin
            if (start_endp_i == 2'(i)) start_toggle = toggle_q[i];
        end
    end

    always_comb begin
        state_d    = state_q;
        pid_d      = pid_q;
        endp_d     = endp_q;
        hs_d       = hs_q;
        zlp_d      = zlp_q;
        underrun_d = underrun_q;
        acked_d    = acked_q;
        cnt_d      = cnt_q;
        flip       = 1'b0;
        crc_clr    = 1'b0;
        crc_en     = 1'b0;
`ifdef USB_IN_TIMEOUT_EN
        timer_d    = timer_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    endp_d     = start_endp_i;
                    hs_d       = stall_i | nak_i;
                    zlp_d      = endpi_zlp_i;
                    underrun_d = 1'b0;
                    acked_d    = 1'b0;
                    cnt_d      = '0;
                    crc_clr    = 1'b1;
                    if (stall_i)           pid_d = PidStall;
                    else if (nak_i)        pid_d = PidNak;
                    else if (start_toggle) pid_d = PidData1;
                    else                   pid_d = PidData0;
                    state_d = StPid;
                end
            end
            StPid: begin
                if (tx_ready_i) begin
                    if (hs_q)       state_d = StFin;
                    else if (zlp_q) state_d = StCrcLo;
                    else            state_d = StData;
                end
            end
            StData: begin
                if (tx_ready_i) begin
                    if (endpi_valid_i) begin
                        crc_en = 1'b1;
                        cnt_d  = cnt_q + CntW'(1);
                        if (endpi_last_i || cnt_q == CntW'(MaxPacket - 1)) state_d = StCrcLo;
                    end else begin
                        underrun_d = 1'b1;
                        state_d    = StCrcLo;
                    end
                end
            end
            StCrcLo: if (tx_ready_i) state_d = StCrcHi;
            StCrcHi: if (tx_ready_i) state_d = StEop;
            StEop: begin
`ifdef USB_IN_TIMEOUT_EN
                timer_d = '0;
`endif
                state_d = StWaitAck;
            end
            StWaitAck: begin
                if (rx_valid_i && valid_pid(rx_data_i)) begin
                    // A packet we poisoned by underrun must never advance the toggle.
                    if (rx_data_i[3:0] == PidAck && !underrun_q) begin
                        flip    = 1'b1;
                        acked_d = 1'b1;
                    end
                    state_d = StFin;
                end
`ifdef USB_IN_TIMEOUT_EN
                else if (!rx_active_i) begin
                    if (timer_q == TmrW'(TimeoutCycles - 1)) state_d = StFin;
                    else timer_d = timer_q + TmrW'(1);
                end
`endif
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NumEndp; i++) begin
            toggle_d[i] = toggle_q[i];
            if (flip && endp_q == 2'(i)) toggle_d[i] = ~toggle_q[i];
            if (toggle_clr_i[i])         toggle_d[i] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            pid_q      <= PidData0;
            endp_q     <= '0;
            hs_q       <= 1'b0;
            zlp_q      <= 1'b0;
            underrun_q <= 1'b0;
            acked_q    <= 1'b0;
            cnt_q      <= '0;
            toggle_q   <= '0;
        end else begin
            state_q    <= state_d;
            pid_q      <= pid_d;
            endp_q     <= endp_d;
            hs_q       <= hs_d;
            zlp_q      <= zlp_d;
            underrun_q <= underrun_d;
            acked_q    <= acked_d;
            cnt_q      <= cnt_d;
            toggle_q   <= toggle_d;
        end
    end

`ifdef USB_IN_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) timer_q <= '0;
        else         timer_q <= timer_d;
    end
`endif

    // Outputs decode straight from state so a reset cuts the packet in the same cycle.
    always_comb begin
        tx_data_o = 8'h00;
        unique case (state_q)
            StPid:   tx_data_o = tx_pid(pid_q);
            StData:  tx_data_o = endpi_data_i;
            StCrcLo: tx_data_o = underrun_q ? crc[7:0] : ~crc[7:0];
            StCrcHi: tx_data_o = underrun_q ? crc[15:8] : ~crc[15:8];
            default: tx_data_o = 8'h00;
        endcase
    end

    assign tx_valid_o    = (state_q == StPid) || (state_q == StData) ||
                           (state_q == StCrcLo) || (state_q == StCrcHi);
    assign endpi_ready_o = tx_ready_i && endpi_valid_i && (state_q == StData);
    assign busy_o        = state_q != StIdle;
    assign done_o        = state_q == StFin;
    assign acked_o       = acked_q;
    assign toggle_o      = toggle_q;

endmodule

// File: doc/usb_in_tx.md
Name: usb_in_tx

Overview:
- Transmit side of the low-speed USB device SIE; handles the IN data stage once the token decoder has accepted an IN token for this device.
- Sends DATA0/DATA1 + payload + CRC16, or a bare NAK/STALL handshake, to the transceiver, then waits for the host ACK.
- Keeps the per-endpoint data toggle.
- Sits between the token decoder, the IN endpoint sources and the NRZI/bit-stuff transceiver.

Parameters:
num_endp, 1, number of IN endpoints (1..3 for low speed)
max_packet, 8, maximum payload bytes per DATA packet
timeout_cycles, 288, clk cycles to wait for the host handshake (18 bit times at 1.5 Mb/s, 24 MHz)

Ports:
clk  input  1  system clock (24 MHz)
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse: IN token accepted, begin data stage
start_endp  input  2  endpoint addressed by the token, sampled on start
nak  input  1  sampled on start: send NAK handshake only
stall  input  1  sampled on start: send STALL only, priority over nak
toggle_clr  input  num_endp  per-endpoint clear of the toggle to DATA0
endpi_data  input  8  payload byte from the selected endpoint
endpi_valid  input  1  endpi_data valid
endpi_last  input  1  current byte is the final payload byte
endpi_zlp  input  1  sampled on start: zero-length packet
endpi_ready  output  1  payload byte consumed this cycle
tx_data  output  8  byte to the transceiver
tx_valid  output  1  rise: SYNC; high: send bytes; fall: EOP
tx_ready  input  1  pulse: transceiver has taken tx_data
rx_data  input  8  received byte
rx_valid  input  1  received byte valid pulse
rx_active  input  1  receiver active between SYNC and EOP
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at the end of the data stage
acked  output  1  qualifies done: host ACK received
toggle  output  num_endp  current data toggle per endpoint

Behaviour:
- Reset (async assert, sync release): all outputs 0, toggle all 0 (DATA0), state IDLE, crc 16'hFFFF.
- States: IDLE, PID, DATA, CRC_LO, CRC_HI, EOP, WAIT_ACK, FIN.
- IDLE: on start, latch endp/nak/stall/zlp.
  - Drive tx_data = {~pid,pid}, tx_valid = 1 the next cycle; go to PID.
  - pid selection: STALL if stall, else NAK if nak, else DATA1 if toggle[endp], else DATA0.
  - start while busy is ignored.
- PID, on tx_ready:
  - Handshake PID: tx_valid <= 0, go to FIN with acked = 0.
  - zlp: go to CRC_LO.
  - Otherwise go to DATA.
- DATA, on tx_ready with endpi_valid:
  - Same cycle: endpi_ready = 1 (combinational, tx_ready && endpi_valid && state == DATA).
  - tx_data <= endpi_data; crc steps LSB-first, poly 16'hA001, init 16'hFFFF; byte count increments.
  - Go to CRC_LO when endpi_last is set or count reaches max_packet. Any remaining bytes stay in the source.
  - Underrun (tx_ready with endpi_valid = 0): set a sticky underrun flag, go to CRC_LO. The CRC is then sent inverted, so the host discards the packet.
- CRC_LO / CRC_HI, on tx_ready: send ~crc[7:0] then ~crc[15:8]. After the high byte's tx_ready, go to EOP.
- EOP: tx_valid <= 0 for at least one cycle; go to WAIT_ACK.
- WAIT_ACK:
  - rx_valid with a valid PID == ACK: toggle[endp] flips; done = 1, acked = 1.
  - Any other valid PID, or the timeout: done = 1, acked = 0, toggle unchanged. The retry re-sends the same toggle.
  - Invalid PID bytes are ignored.
  - The timeout counter starts at EOP entry and counts while rx_active = 0.
- FIN: one cycle, done pulse; back to IDLE. acked is held until the next start.
- toggle_clr[i] forces toggle[i] = 0 and wins over a same-cycle ACK flip.
- Reset mid-packet drops tx_valid immediately (truncated packet; the host sees a bit error).

Optional Feature:
- USB_IN_TIMEOUT_EN defined: the timeout counter is built; WAIT_ACK exits after timeout_cycles idle cycles.
- Not defined: no counter; WAIT_ACK exits only on receipt of a valid PID byte (ACK → acked; any other → not acked). Relies on the host sending a next token.

Decomposition:
- Shared types package gets: pid_t (DATA0, DATA1, ACK, NAK, STALL, ...), the CRC16 polynomial, init and residual constants, valid_pid, tx_pid and step_crc16 functions. These are shared with the receive-side SIE.
- One natural sub-module: usb_crc16_gen (byte-wide LSB-first step with clear and enable).

Test Plan:
- Reset, toggle 0; start, endp 0, payload single 0x00 (last = 1); ACK 0xD2 returned → wire bytes C3 00 40 BF, then done = 1, acked = 1, toggle[0] = 1.
- toggle[1] = 1, start endp 1, zlp = 1 → wire bytes 4B 00 00; no ACK → done after 288 cycles (macro on), acked = 0, toggle[1] stays 1.
- nak = 1 → single byte 5A, tx_valid falls after its tx_ready, done with acked = 0; stall = nak = 1 → 1E only.
- Source streams 10 bytes with max_packet = 8 → exactly 8 endpi_ready pulses, then 2 CRC bytes; bytes 9–10 untouched.
- endpi_valid low at the 3rd data tx_ready → CRC sent inverted versus the model, underrun set, no toggle flip even if ACK arrives.
- toggle_clr[0] in the same cycle as an ACK on endp 0 → toggle[0] = 0; assert reset during DATA → tx_valid = 0 and all outputs 0 within the same cycle.
